// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: streams operands LSB-first through an external 1-bit slice.
// Optional zero flag output enabled by defining BIT_SERIAL_ALU_ZERO_FLAG_EN.
module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             borrow_in,
    output logic             op1,
    output logic             op2,
    output logic             cin,
    output logic [2:0]       opsel,
    input  logic             result,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] y_next;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             init_carry;
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
    logic             zero_q;
`endif

    always_comb begin
        init_carry = 1'b0;
        case (op)
            3'b011:  init_carry = borrow_in;
            3'b101:  init_carry = 1'b1;
            default: init_carry = 1'b0;
        endcase
    end

    // Slice interface is quiet outside RUN; busy is high exactly in RUN.
    assign op1    = busy ? a_sh[0] : 1'b0;
    assign op2    = busy ? b_sh[0] : 1'b0;
    assign cin    = busy ? carry_q : 1'b0;
    assign opsel  = busy ? op_q    : 3'b000;
    assign y_next = {result, y_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            y         <= '0;
            carry_out <= 1'b0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            y_sh      <= '0;
            op_q      <= 3'b000;
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
            zero_q    <= 1'b0;
            zero      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        op_q    <= op;
                        cnt     <= '0;
                        carry_q <= init_carry;
                        busy    <= 1'b1;
                        state   <= RUN;
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
                        zero_q  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    y_sh    <= y_next;
                    carry_q <= cout;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + CW'(1);
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
                    zero_q  <= zero_q & ~result;
`endif
                    // The final bit is folded in directly so y is valid on entry to DONE.
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        y         <= y_next;
                        carry_out <= cout;
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
                        zero      <= zero_q & ~result;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq (WIDTH=8) with a behavioural 1-bit slice.
module tb_bit_serial_alu_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       borrow_in = 1'b0;
    logic       op1, op2, cin, result, cout, busy, done, carry_out;
    logic [2:0] opsel;
    logic [7:0] y;
    logic       zero;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    bit_serial_alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
        .borrow_in(borrow_in), .op1(op1), .op2(op2), .cin(cin), .opsel(opsel),
        .result(result), .cout(cout), .busy(busy), .done(done), .y(y),
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
        .zero(zero),
`endif
        .carry_out(carry_out)
    );

`ifndef BIT_SERIAL_ALU_ZERO_FLAG_EN
    assign zero = 1'b0;
`endif

    // Slice: add, subtract with borrow, decrement, and simple logic ops.
    always_comb begin
        result = 1'b0;
        cout   = 1'b0;
        case (opsel)
            3'b000: {cout, result} = {1'b0, op1} + {1'b0, op2} + {1'b0, cin};
            3'b001, 3'b011: begin
                result = op1 ^ op2 ^ cin;
                cout   = (~op1 & op2) | (~(op1 ^ op2) & cin);
            end
            3'b101: begin
                result = op1 ^ cin;
                cout   = ~op1 & cin;
            end
            3'b010:  result = op1 & op2;
            3'b100:  result = op1 | op2;
            3'b110:  result = op1 ^ op2;
            default: result = ~op1;
        endcase
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (y !== 8'h00) begin n_bad++; $display("FAIL reset_y got %h want 00", y); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", carry_out); end
        n_cmp++; if ({op1, op2, cin, opsel} !== 6'b0) begin n_bad++; $display("FAIL reset_slice got %b want 000000", {op1, op2, cin, opsel}); end
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
        n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", zero); end
`endif
        reset = 1'b0;
        start = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_dominates busy got %b want 0", busy); end
    endtask

    // Caller is positioned just after an edge; start is asserted for the current cycle.
    task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] va,
                          input logic [7:0] vb, input logic bin, input logic [7:0] ey,
                          input logic ec, input logic ez);
        int cyc;
        a = va; b = vb; op = o; borrow_in = bin; start = 1'b1;
        tick();
        start = 1'b0; a = 8'hA5; b = 8'h5A; op = 3'b111; borrow_in = ~bin;
        cyc = 1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_c1 got %b want 1", name, busy); end
        n_cmp++; if ({opsel, op1, op2} !== {o, va[0], vb[0]})
            begin n_bad++; $display("FAIL %s slice_c1 got %b want %b", name, {opsel, op1, op2}, {o, va[0], vb[0]}); end
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL %s latency got %0d want 9", name, cyc); end
        n_cmp++; if (y !== ey) begin n_bad++; $display("FAIL %s y got %h want %h", name, y, ey); end
        n_cmp++; if (carry_out !== ec) begin n_bad++; $display("FAIL %s carry_out got %b want %b", name, carry_out, ec); end
`ifdef BIT_SERIAL_ALU_ZERO_FLAG_EN
        n_cmp++; if (zero !== ez) begin n_bad++; $display("FAIL %s zero got %b want %b", name, zero, ez); end
`else
        if (ez) begin end
`endif
        n_cmp++; if ({busy, opsel, cin} !== 5'b0) begin n_bad++; $display("FAIL %s idle_slice got %b want 00000", name, {busy, opsel, cin}); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s done_pulse got %b want 0", name, done); end
        n_cmp++; if (y !== ey) begin n_bad++; $display("FAIL %s y_hold got %h want %h", name, y, ey); end
    endtask

    task automatic test_arith();
        run_op("add",      3'b000, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
        run_op("add_wrap", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("sub",      3'b001, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        run_op("sub_wrap", 3'b001, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("sbc",      3'b011, 8'h05, 8'h02, 1'b1, 8'h02, 1'b0, 1'b0);
        run_op("dec",      3'b101, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        int cyc;
        int d0;
        int done_cyc;
        d0 = done_cnt;
        done_cyc = 0;
        a = 8'h12; b = 8'h34; op = 3'b000; start = 1'b1;
        tick();
        cyc = 1;
        start = 1'b0;
        a = 8'hFF; b = 8'hFF;
        while (cyc < 14) begin
            start = (cyc == 3 || cyc == 9);
            tick();
            cyc++;
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        tick();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ignore_start done_count got %0d want 1", done_cnt - d0); end
        n_cmp++; if (done_cyc !== 9) begin n_bad++; $display("FAIL ignore_start done_cycle got %0d want 9", done_cyc); end
        n_cmp++; if (y !== 8'h46) begin n_bad++; $display("FAIL ignore_start y got %h want 46", y); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_start busy got %b want 0", busy); end
    endtask

    task automatic test_reset_midrun();
        int d0;
        d0 = done_cnt;
        a = 8'h5A; b = 8'h3C; op = 3'b000; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_reset busy got %b want 0", busy); end
        n_cmp++; if (y !== 8'h00) begin n_bad++; $display("FAIL midrun_reset y got %h want 00", y); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL midrun_reset cout got %b want 0", carry_out); end
        repeat (10) tick();
        n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL midrun_reset done_count got %0d want %0d", done_cnt, d0); end
        run_op("after_reset", 3'b000, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        tick();
        test_reset();
        test_arith();
        test_ignore_start();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
